// File: rtl/reset_sequencer.sv
// Board reset fan-out: holds NUM_DOMAINS resets low after POR, releases them in ascending
// staggered order, and re-runs the release on a software request or watchdog timeout.
module reset_sequencer #(
    parameter int unsigned NUM_DOMAINS    = 4,
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned STAGGER_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES    = 8,
    parameter int unsigned WDT_CYCLES     = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   soft_rst_req_i,
    input  logic                   wdt_en_i,
    input  logic                   wdt_kick_i,
    output logic [NUM_DOMAINS-1:0] rst_n_o,
    output logic                   done_o,
    output logic [1:0]             cause_o
);

    localparam int unsigned MAX_A   = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAX_CNT = (MAX_A > STAGGER_CYCLES) ? MAX_A : STAGGER_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int unsigned IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int unsigned WDT_W   = $clog2(WDT_CYCLES);

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_SOFT = 2'd1;
    localparam logic [1:0] CAUSE_WDT  = 2'd2;

    typedef enum logic [1:0] {
        ST_STABILIZE,
        ST_RELEASE,
        ST_RUN,
        ST_HOLD
    } state_e;

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic [WDT_W-1:0]       wdt_q;
    logic [NUM_DOMAINS-1:0] rst_n_q;
    logic                   done_q;
    logic [1:0]             cause_q;

    logic wdt_expire_d;
    logic first_release_d;
    logic stagger_tick_d;

    always_comb begin
        wdt_expire_d    = wdt_en_i && !wdt_kick_i && (wdt_q == WDT_W'(WDT_CYCLES - 1));
        first_release_d = ((state_q == ST_STABILIZE) && (cnt_q == CNT_W'(STABLE_CYCLES - 1))) ||
                          ((state_q == ST_HOLD)      && (cnt_q == CNT_W'(HOLD_CYCLES - 1)));
        stagger_tick_d  = (cnt_q == CNT_W'(STAGGER_CYCLES - 1));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_STABILIZE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdt_q   <= '0;
            rst_n_q <= '0;
            done_q  <= 1'b0;
            cause_q <= CAUSE_POR;
        end else begin
            case (state_q)
                // STABILIZE and HOLD differ only in their wait length
                ST_STABILIZE, ST_HOLD: begin
                    if (first_release_d) begin
                        cnt_q      <= '0;
                        rst_n_q[0] <= 1'b1;
                        if (NUM_DOMAINS == 1) begin
                            state_q <= ST_RUN;
                            done_q  <= 1'b1;
                            wdt_q   <= '0;
                        end else begin
                            state_q <= ST_RELEASE;
                            idx_q   <= IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (stagger_tick_d) begin
                        cnt_q          <= '0;
                        rst_n_q[idx_q] <= 1'b1;
                        if (idx_q == IDX_W'(NUM_DOMAINS - 1)) begin
                            state_q <= ST_RUN;
                            done_q  <= 1'b1;
                            wdt_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (soft_rst_req_i || wdt_expire_d) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        wdt_q   <= '0;
                        rst_n_q <= '0;
                        done_q  <= 1'b0;
                        cause_q <= soft_rst_req_i ? CAUSE_SOFT : CAUSE_WDT;
                    end else if (!wdt_en_i || wdt_kick_i) begin
                        wdt_q <= '0;
                    end else begin
                        wdt_q <= wdt_q + 1'b1;
                    end
                end
                default: state_q <= ST_STABILIZE;
            endcase
        end
    end

    assign rst_n_o = rst_n_q;
    assign done_o  = done_q;
    assign cause_o = cause_q;

endmodule
